fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences the PC register and the instruction-memory port for the RV32I pipeline IF stage.
//  Drives PC enable and next-PC, issues one-outstanding imem requests, and delivers instr/pc to IF/ID.
//  Absorbs load-use stalls, EX-stage redirects (branch/JAL/JALR) and misaligned-target traps.
// PARAMETERS
//  XLEN      32            address/data width
//  TRAP_VEC  32'h0000_0100 next PC on misaligned redirect target
// PORTS
//  clk            in   1     clock; all state on rising edge
//  reset          in   1     synchronous, active-high
//  pc_cur         in   XLEN  current PC (PC register output)
//  pc_next        out  XLEN  PC register input
//  pc_en          out  1     PC register enable
//  stall_i        in   1     hazard unit: IF/ID must hold
//  redirect_valid in   1     EX redirect strobe
//  redirect_pc    in   XLEN  redirect target
//  imem_req       out  1     fetch request
//  imem_addr      out  XLEN  fetch address
//  imem_gnt       in   1     request accepted this cycle
//  imem_rvalid    in   1     response valid
//  imem_rdata     in   32    response instruction
//  if_valid       out  1     instr/pc valid to IF/ID
//  if_instr       out  32    fetched instruction
//  if_pc          out  XLEN  address of if_instr
//  misalign_err   out  1     one-cycle pulse: redirect_pc[1:0]!=0
// BEHAVIOUR
//  Reset: state=IDLE, drop=0; all outputs 0 (pc_next=0, pc_en=0). Reset mid-fetch abandons request;
//   imem is reset by the same reset, so no stale response follows.
//  States: IDLE -> REQ (unconditional, 1 cycle). REQ: imem_req=1, imem_addr=pc_cur;
//   on imem_gnt latch fetch_pc=pc_cur, -> WAIT. WAIT: on imem_rvalid: drop=1 -> clear drop, no if_valid, -> REQ;
//   else if_valid=1 combinationally (if_instr=imem_rdata, if_pc=fetch_pc); !stall_i -> pc_en=1, pc_next=fetch_pc+4, -> REQ;
//   stall_i -> capture into hold buffer, -> HOLD. HOLD: if_valid=1 from buffer; on !stall_i pc_en=1,
//   pc_next=buffered pc+4, -> REQ.
//  Latency: gnt same cycle as req, rvalid next cycle -> 2 cycles/instr (REQ, WAIT); one outstanding request max.
//  Redirect (any state except IDLE) has priority over stall and PC advance: pc_en=1,
//   pc_next=redirect_pc (TRAP_VEC + misalign_err=1 if redirect_pc[1:0]!=0); if_valid forced 0 that cycle.
//   REQ without gnt: -> REQ (new address next cycle). REQ with gnt, or WAIT without rvalid: set drop=1, -> WAIT.
//   WAIT with rvalid same cycle: response discarded, -> REQ. HOLD: buffer discarded, -> REQ.
//  imem_rvalid outside WAIT ignored. Arithmetic: pc+4 mod 2^XLEN (wrap 32'hFFFF_FFFC -> 0, no flag).
//  pc_en=0 and pc_next=pc_cur whenever not advancing or redirecting.
// STRUCTURE
//  Package rv_fetch_pkg: fetch_state_t enum {IDLE,REQ,WAIT,HOLD}, PC_INC=4, default TRAP_VEC.
//  Sub-module fetch_hold_buf: one-entry instr/pc register, load/clear/valid; FSM+next-PC mux in top.
//  Estimated 150-250 lines RTL.
// TESTING
//  1 Reset, imem gnt always, rvalid 1 cycle later, no stall -> if_pc 0,4,8,12 every 2 cycles; pc_en pulses.
//  2 stall_i high 3 cycles while rvalid at pc=8 -> HOLD; if_valid/if_pc=8 held 3 cycles; then pc_next=12.
//  3 redirect_valid, redirect_pc=0x40 while WAIT for pc=4 -> pc_next=0x40; response for 4 dropped; next if_pc=0x40.
//  4 redirect_pc=0x42 -> misalign_err one cycle, pc_next=0x100, next if_pc=0x100.
//  5 redirect coincident with stall_i and rvalid -> redirect wins, if_valid=0, no HOLD entry.
//  6 reset asserted in WAIT -> next cycle all outputs 0, state IDLE; pc_cur=0xFFFF_FFFC delivered -> pc_next=0.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch controller.
package rv_fetch_pkg;

    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry instr/pc buffer that parks a fetched instruction while IF/ID is stalled.
module fetch_hold_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [31:0]     load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: PC enable/next-PC, one-outstanding imem requests, IF/ID delivery.
module fetch_ctrl
    import rv_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_cur,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_en,
    input  logic            stall_i,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            misalign_err
);

    fetch_state_t    state_q, state_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

    logic            buf_load, buf_clear, buf_valid;
    logic [31:0]     buf_instr;
    logic [XLEN-1:0] buf_pc;

    logic            redirect_taken;
    logic            target_misaligned;
    logic [XLEN-1:0] redirect_target;

    assign redirect_taken    = redirect_valid && (state_q != IDLE);
    assign target_misaligned = (redirect_pc[1:0] != 2'b00);
    assign redirect_target   = target_misaligned ? TRAP_VEC : redirect_pc;

    fetch_hold_buf #(
        .XLEN (XLEN)
    ) u_hold_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_instr (imem_rdata),
        .load_pc    (fetch_pc_q),
        .valid      (buf_valid),
        .instr      (buf_instr),
        .pc         (buf_pc)
    );

    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        fetch_pc_d   = fetch_pc_q;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;
        pc_en        = 1'b0;
        pc_next      = pc_cur;
        imem_req     = 1'b0;
        imem_addr    = '0;
        if_valid     = 1'b0;
        if_instr     = '0;
        if_pc        = '0;
        misalign_err = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc_cur;
                if (imem_gnt) begin
                    fetch_pc_d = pc_cur;
                    state_d    = WAIT;
                    // A redirect in the grant cycle makes the in-flight fetch stale.
                    if (redirect_valid) begin
                        drop_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        if_valid = 1'b1;
                        if_instr = imem_rdata;
                        if_pc    = fetch_pc_q;
                        if (stall_i) begin
                            buf_load = 1'b1;
                            state_d  = HOLD;
                        end else begin
                            pc_en   = 1'b1;
                            pc_next = fetch_pc_q + XLEN'(PC_INC);
                            state_d = REQ;
                        end
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if_valid = buf_valid;
                if_instr = buf_instr;
                if_pc    = buf_pc;
                if (redirect_valid) begin
                    buf_clear = 1'b1;
                    state_d   = REQ;
                end else if (!stall_i) begin
                    pc_en     = 1'b1;
                    pc_next   = buf_pc + XLEN'(PC_INC);
                    buf_clear = 1'b1;
                    state_d   = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect overrides PC advance and suppresses delivery this cycle.
        if (redirect_taken) begin
            pc_en        = 1'b1;
            pc_next      = redirect_target;
            misalign_err = target_misaligned;
            if_valid     = 1'b0;
            if_instr     = '0;
            if_pc        = '0;
        end

        if (reset) begin
            pc_en        = 1'b0;
            pc_next      = '0;
            imem_req     = 1'b0;
            imem_addr    = '0;
            if_valid     = 1'b0;
            if_instr     = '0;
            if_pc        = '0;
            misalign_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            drop_q     <= 1'b0;
            fetch_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and imem environment, flag-based reference model, directed cases.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_cur = 32'h0;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        stall_i = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;
    logic done = 1'b0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .XLEN     (32),
        .TRAP_VEC (32'h0000_0100)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .pc_en          (pc_en),
        .stall_i        (stall_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .misalign_err   (misalign_err)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    // Environment: PC register and a one-cycle-latency instruction memory.
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic        rv_block = 1'b0;
    logic        stray = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_load_val = 32'h0;

    assign imem_rvalid = (pend && !rv_block) || stray;
    assign imem_rdata  = pend ? instr_of(pend_addr) : (stray ? 32'hDEAD_BEEF : 32'h0);

    always @(posedge clk) begin
        if (pc_load)     pc_cur <= pc_load_val;
        else if (reset)  pc_cur <= 32'h0;
        else if (pc_en)  pc_cur <= pc_next;

        if (reset) begin
            pend <= 1'b0;
        end else if (imem_req && imem_gnt) begin
            pend      <= 1'b1;
            pend_addr <= imem_addr;
        end else if (pend && !rv_block) begin
            pend <= 1'b0;
        end
    end

    // Reference model: idle after reset, else requesting, awaiting a response, or holding one.
    logic        m_idle = 1'b1;
    logic        m_inflight = 1'b0;
    logic        m_discard = 1'b0;
    logic [31:0] m_fpc = 32'h0;
    logic        m_held = 1'b0;
    logic [31:0] m_hpc = 32'h0;
    logic [31:0] m_hinstr = 32'h0;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        pc_en;
        logic [31:0] pc_next;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        if (reset) return e;
        e.pc_next = pc_cur;
        if (m_idle) return e;
        if (m_held) begin
            e.valid = 1'b1;
            e.instr = m_hinstr;
            e.pc    = m_hpc;
            if (!stall_i) begin
                e.pc_en   = 1'b1;
                e.pc_next = m_hpc + 32'd4;
            end
        end else if (m_inflight) begin
            if (imem_rvalid && !m_discard) begin
                e.valid = 1'b1;
                e.instr = instr_of(m_fpc);
                e.pc    = m_fpc;
                if (!stall_i) begin
                    e.pc_en   = 1'b1;
                    e.pc_next = m_fpc + 32'd4;
                end
            end
        end else begin
            e.req  = 1'b1;
            e.addr = pc_cur;
        end
        if (redirect_valid) begin
            e.mis     = (redirect_pc[1:0] != 2'b00);
            e.pc_en   = 1'b1;
            e.pc_next = e.mis ? 32'h0000_0100 : redirect_pc;
            e.valid   = 1'b0;
            e.instr   = 32'h0;
            e.pc      = 32'h0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_idle     <= 1'b1;
            m_inflight <= 1'b0;
            m_discard  <= 1'b0;
            m_held     <= 1'b0;
        end else if (m_idle) begin
            m_idle <= 1'b0;
        end else if (m_held) begin
            if (redirect_valid || !stall_i) m_held <= 1'b0;
        end else if (m_inflight) begin
            if (imem_rvalid) begin
                m_inflight <= 1'b0;
                m_discard  <= 1'b0;
                if (!m_discard && !redirect_valid && stall_i) begin
                    m_held   <= 1'b1;
                    m_hpc    <= m_fpc;
                    m_hinstr <= instr_of(m_fpc);
                end
            end else if (redirect_valid) begin
                m_discard <= 1'b1;
            end
        end else if (imem_gnt) begin
            m_inflight <= 1'b1;
            m_fpc      <= pc_cur;
            m_discard  <= redirect_valid;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!done) begin
            e = model_out();
            check("m_imem_req", 32'(imem_req), 32'(e.req));
            check("m_pc_en", 32'(pc_en), 32'(e.pc_en));
            check("m_pc_next", pc_next, e.pc_next);
            check("m_if_valid", 32'(if_valid), 32'(e.valid));
            check("m_misalign", 32'(misalign_err), 32'(e.mis));
            if (reset || e.req) check("m_imem_addr", imem_addr, e.addr);
            if (reset || e.valid) begin
                check("m_if_pc", if_pc, e.pc);
                check("m_if_instr", if_instr, e.instr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_deliver(input logic [31:0] pc, input logic [31:0] nxt);
        int n = 0;
        @(negedge clk);
        while (!if_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("deliver_valid", 32'(if_valid), 32'd1);
        check("deliver_pc", if_pc, pc);
        check("deliver_instr", if_instr, instr_of(pc));
        if (!stall_i) begin
            check("advance_en", 32'(pc_en), 32'd1);
            check("advance_next", pc_next, nxt);
        end
        tick();
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("reset_req", 32'(imem_req), 32'd0);
        check("reset_pc_en", 32'(pc_en), 32'd0);
        check("reset_pc_next", pc_next, 32'd0);
        check("reset_if_valid", 32'(if_valid), 32'd0);
        tick();
        reset = 1'b0;

        // Streaming fetch, no stalls
        expect_deliver(32'h0, 32'h4);
        expect_deliver(32'h4, 32'h8);

        // Stall for three cycles while pc=8 is delivered
        stall_i = 1'b1;
        expect_deliver(32'h8, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(if_valid), 32'd1);
            check("hold_pc", if_pc, 32'h8);
            check("hold_pc_en", 32'(pc_en), 32'd0);
            tick();
        end
        stall_i = 1'b0;
        @(negedge clk);
        check("release_pc_en", 32'(pc_en), 32'd1);
        check("release_pc_next", pc_next, 32'hC);
        check("release_pc", if_pc, 32'h8);
        tick();
        expect_deliver(32'hC, 32'h10);

        // Redirect while waiting on an unanswered fetch
        rv_block = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        check("redir_pc_en", 32'(pc_en), 32'd1);
        check("redir_pc_next", pc_next, 32'h40);
        check("redir_if_valid", 32'(if_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        rv_block       = 1'b0;
        @(negedge clk);
        check("stale_dropped", 32'(if_valid), 32'd0);
        tick();
        expect_deliver(32'h40, 32'h44);

        // Misaligned redirect target traps
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        @(negedge clk);
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_pc_next", pc_next, 32'h100);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("mis_pulse_end", 32'(misalign_err), 32'd0);
        tick();
        expect_deliver(32'h100, 32'h104);

        // Grant withheld, then redirect + stall + rvalid together
        imem_gnt = 1'b0;
        @(negedge clk);
        check("nogrant_req", 32'(imem_req), 32'd1);
        check("nogrant_addr", imem_addr, 32'h104);
        tick();
        imem_gnt = 1'b1;
        tick();
        stall_i        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        check("combo_if_valid", 32'(if_valid), 32'd0);
        check("combo_pc_next", pc_next, 32'h200);
        tick();
        stall_i        = 1'b0;
        redirect_valid = 1'b0;
        stray          = 1'b1;
        @(negedge clk);
        check("combo_no_hold_req", 32'(imem_req), 32'd1);
        check("combo_no_hold_addr", imem_addr, 32'h200);
        check("stray_ignored", 32'(if_valid), 32'd0);
        tick();
        stray = 1'b0;
        expect_deliver(32'h200, 32'h204);

        // Reset mid-fetch, then PC wrap at the top of the address space
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("midreset_req", 32'(imem_req), 32'd0);
        check("midreset_if_valid", 32'(if_valid), 32'd0);
        tick();
        reset       = 1'b0;
        pc_load     = 1'b1;
        pc_load_val = 32'hFFFF_FFFC;
        @(negedge clk);
        check("idle_req", 32'(imem_req), 32'd0);
        check("idle_pc_en", 32'(pc_en), 32'd0);
        check("idle_pc_next", pc_next, 32'd0);
        tick();
        pc_load = 1'b0;
        expect_deliver(32'hFFFF_FFFC, 32'h0);

        repeat (3) tick();
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
